tawas_dmem: RTL and testbench
=============================

// Module: tawas_dmem
// PURPOSE
//  Data-side responder for the tawas core data bus (DADDR/DCS/DWR/DMASK/DOUT/DIN).
//  Single-port byte-maskable data RAM plus a small MMIO block: cycle counter,
//  scratch register, compare timer with IRQ, and a sticky bus-error flag.
//  Port names match the core so the top level connects by name. DOUT is write
//  data into this block; DIN is read data back to the core.
// PARAMETERS
//  ADDR_WIDTH  12  word-address bits of the RAM. Depth is 2**ADDR_WIDTH words (16 KB at default).
// PORTS
//  CLK    in   1   clock; single clock domain
//  RST    in   1   reset, asynchronous, active-high
//  DADDR  in   32  byte address; DADDR[1:0] ignored
//  DCS    in   1   access strobe, one access per cycle
//  DWR    in   1   1 = write, 0 = read (qualified by DCS)
//  DMASK  in   4   byte enables; bit i enables DOUT[8i+7:8i]
//  DOUT   in   32  write data
//  DIN    out  32  read data, registered
//  IRQ    out  1   timer interrupt (level)
//  BUS_ERR out 1   sticky out-of-range access flag
// BEHAVIOUR
//  - Reset values: DIN=0, IRQ=0, BUS_ERR=0, CYCLE=0, SCRATCH=0, TIMER_CMP=0, CTRL=0, STATUS=0.
//    RAM contents are not reset; they are retained across RST.
//  - Decode:
//      DADDR[31]=1: MMIO, register = DADDR[4:2], DADDR[30:5] ignored.
//      DADDR[31]=0 and DADDR[30:ADDR_WIDTH+2]==0: RAM word DADDR[ADDR_WIDTH+1:2].
//      Anything else is out of range.
//  - Read (DCS & ~DWR) at edge N: DIN holds the data from edge N+1 onward (1-cycle latency).
//    DIN holds its last value while no read occurs.
//  - Write (DCS & DWR): masked bytes are committed at the edge; unmasked bytes are unchanged.
//    DMASK=0 is a legal no-op. A read in the next cycle returns the new data.
//  - Out of range: write dropped; read returns 0; BUS_ERR/STATUS[1] set at the same edge.
//  - MMIO map (word offset):
//      0 CYCLE      RO; +1 every cycle, wraps 0xFFFFFFFF->0; writes ignored.
//      1 SCRATCH    RW, byte-masked.
//      2 TIMER_CMP  RW, byte-masked.
//      3 STATUS     [0] irq_pending, [1] bus_err; W1C on masked byte 0; reads 0 above bit 1.
//      4 CTRL       [0] timer_en, [1] irq_en; RW; reads 0 above bit 1.
//      5-7          read 0, writes ignored.
//  - Timer: on any cycle with timer_en=1 and CYCLE==TIMER_CMP (pre-increment value),
//    irq_pending sets at that edge.
//  - IRQ = irq_pending & irq_en, registered; it rises one cycle after irq_pending.
//  - Set and W1C clear in the same cycle: set wins (applies to both STATUS bits).
//  - RST mid-access: the access is abandoned; a pending read never updates DIN.
// CONFIGURATION
//  TAWAS_DMEM_TIMER_EN defined: timer, TIMER_CMP, CTRL and IRQ are as above.
//  Not defined: offsets 2 and 4 read 0 and ignore writes; irq_pending is never set;
//  IRQ is tied 0. CYCLE, SCRATCH and BUS_ERR are unaffected.
// STRUCTURE
//  - tawas_pkg holds the MMIO offsets (CYCLE..CTRL), the STATUS/CTRL bit positions
//    and the MMIO select bit (31).
//  - Sub-module tawas_dmem_ram: single-port synchronous RAM, 2**ADDR_WIDTH x 32,
//    per-byte write enable, registered read.
//  - The top level handles decode, the MMIO registers, the timer and the DIN mux.
// TESTING
//  1. Write 0x11223344 to 0x10, DMASK=1111; read 0x10 -> DIN=0x11223344 one cycle later.
//  2. Then write 0xAABBCCDD to 0x10, DMASK=0010; read 0x10 -> DIN=0x1122CC44.
//  3. Read 0x0001_0000 (ADDR_WIDTH=12) -> DIN=0, BUS_ERR=1; write 0x2 to STATUS -> BUS_ERR=0.
//  4. TIMER_EN build: TIMER_CMP=100, CTRL=3 -> IRQ=1 one cycle after CYCLE==100;
//     write 0x1 to STATUS -> IRQ=0. Non-TIMER_EN build: IRQ stays 0, offset 2 reads 0.
//  5. Read CYCLE at edges N and N+10 -> difference is 10. SCRATCH write 0xFFFFFFFF,
//     DMASK=1000 -> reads 0xFF000000.
//  6. Assert RST in the cycle after a read of 0x10 -> DIN=0, all registers cleared;
//     after release, read 0x10 returns its retained RAM data.

Source files
------------

// File: rtl/tawas_pkg.sv
// Shared definitions for the tawas data-side responder: MMIO map, register bit
// positions and the byte-merge helper.
package tawas_pkg;

  localparam int unsigned MMIO_SEL_BIT = 31;

  typedef enum logic [2:0] {
    OffCycle    = 3'd0,
    OffScratch  = 3'd1,
    OffTimerCmp = 3'd2,
    OffStatus   = 3'd3,
    OffCtrl     = 3'd4
  } mmio_off_e;

  localparam int unsigned STATUS_IRQ     = 0;
  localparam int unsigned STATUS_BUS_ERR = 1;
  localparam int unsigned CTRL_TIMER_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN    = 1;

  typedef enum logic {SrcReg, SrcRam} rd_src_e;

  function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tawas_dmem_ram.sv
// Single-port synchronous data RAM with per-byte write enables and a registered
// read port. The array itself is never reset.
module tawas_dmem_ram #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tawas_dmem.sv
// Data-bus responder for the tawas core: byte-maskable RAM plus MMIO block.
// Define TAWAS_DMEM_TIMER_EN to build the compare timer, CTRL and IRQ.
module tawas_dmem
  import tawas_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DADDR,
  input  logic        DCS,
  input  logic        DWR,
  input  logic [3:0]  DMASK,
  input  logic [31:0] DOUT,
  output logic [31:0] DIN,
  output logic        IRQ,
  output logic        BUS_ERR
);

  logic        is_mmio, is_ram, is_oor, rd, mmio_wr;
  logic [2:0]  off;
  logic [31:0] ram_rdata, mmio_rdata;
  logic [31:0] cycle_q, scratch_q, scratch_d, timer_cmp_q;
  logic [1:0]  status_q, status_d, ctrl_q;
  logic        timer_hit;
  rd_src_e     rd_src_q, rd_src_d;
  logic [31:0] reg_rdata_q, reg_rdata_d;
  logic        unused_addr;

  assign unused_addr = ^DADDR[1:0];

  assign is_mmio = DADDR[MMIO_SEL_BIT];
  assign is_ram  = !is_mmio && (DADDR[30:ADDR_WIDTH+2] == '0);
  assign is_oor  = !is_mmio && !is_ram;
  assign off     = DADDR[4:2];
  assign rd      = DCS && !DWR;
  assign mmio_wr = DCS && DWR && is_mmio;

  tawas_dmem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (CLK),
    .rst  (RST),
    .en   (DCS && is_ram),
    .we   (DWR),
    .be   (DMASK),
    .addr (DADDR[ADDR_WIDTH+1:2]),
    .wdata(DOUT),
    .rdata(ram_rdata)
  );

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OffCycle:    mmio_rdata = cycle_q;
      OffScratch:  mmio_rdata = scratch_q;
      OffTimerCmp: mmio_rdata = timer_cmp_q;
      OffStatus:   mmio_rdata = {30'd0, status_q};
      OffCtrl:     mmio_rdata = {30'd0, ctrl_q};
      default:     mmio_rdata = '0;
    endcase
  end

  always_comb begin
    scratch_d   = scratch_q;
    status_d    = status_q;
    rd_src_d    = rd_src_q;
    reg_rdata_d = reg_rdata_q;
    if (mmio_wr && off == OffScratch) scratch_d = apply_mask(scratch_q, DOUT, DMASK);
    if (mmio_wr && off == OffStatus && DMASK[0]) status_d = status_q & ~DOUT[1:0];
    // Sets are applied after the W1C so a coincident set wins.
    if (DCS && is_oor) status_d[STATUS_BUS_ERR] = 1'b1;
    if (timer_hit) status_d[STATUS_IRQ] = 1'b1;
    if (rd) begin
      rd_src_d    = is_ram ? SrcRam : SrcReg;
      reg_rdata_d = is_mmio ? mmio_rdata : '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_q     <= '0;
      scratch_q   <= '0;
      status_q    <= '0;
      rd_src_q    <= SrcReg;
      reg_rdata_q <= '0;
    end else begin
      cycle_q     <= cycle_q + 32'd1;
      scratch_q   <= scratch_d;
      status_q    <= status_d;
      rd_src_q    <= rd_src_d;
      reg_rdata_q <= reg_rdata_d;
    end
  end

`ifdef TAWAS_DMEM_TIMER_EN
  logic [31:0] timer_cmp_d;
  logic [1:0]  ctrl_d;
  logic        irq_q;

  always_comb begin
    timer_cmp_d = timer_cmp_q;
    ctrl_d      = ctrl_q;
    if (mmio_wr && off == OffTimerCmp) timer_cmp_d = apply_mask(timer_cmp_q, DOUT, DMASK);
    if (mmio_wr && off == OffCtrl && DMASK[0]) ctrl_d = DOUT[1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_cmp_q <= '0;
      ctrl_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      timer_cmp_q <= timer_cmp_d;
      ctrl_q      <= ctrl_d;
      irq_q       <= status_q[STATUS_IRQ] && ctrl_q[CTRL_IRQ_EN];
    end
  end

  assign timer_hit = ctrl_q[CTRL_TIMER_EN] && (cycle_q == timer_cmp_q);
  assign IRQ       = irq_q;
`else
  assign timer_cmp_q = '0;
  assign ctrl_q      = '0;
  assign timer_hit   = 1'b0;
  assign IRQ         = 1'b0;
`endif

  assign DIN     = (rd_src_q == SrcRam) ? ram_rdata : reg_rdata_q;
  assign BUS_ERR = status_q[STATUS_BUS_ERR];

endmodule

// File: tb/tb_tawas_dmem.sv
// Directed bench for tawas_dmem: vector table for single accesses plus
// hand-written sequences for timer, cycle counter and reset retention.
module tb_tawas_dmem;

  logic        CLK;
  logic        RST;
  logic [31:0] DADDR;
  logic        DCS;
  logic        DWR;
  logic [3:0]  DMASK;
  logic [31:0] DOUT;
  logic [31:0] DIN;
  logic        IRQ;
  logic        BUS_ERR;

  int n_cmp = 0;
  int n_err = 0;

  tawas_dmem #(
    .ADDR_WIDTH(12)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .DADDR  (DADDR),
    .DCS    (DCS),
    .DWR    (DWR),
    .DMASK  (DMASK),
    .DOUT   (DOUT),
    .DIN    (DIN),
    .IRQ    (IRQ),
    .BUS_ERR(BUS_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] exp_din;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus access, driven at the falling edge, committed at the next rising edge.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data);
    @(negedge CLK);
    DCS   = 1'b1;
    DWR   = wr;
    DADDR = addr;
    DMASK = mask;
    DOUT  = data;
    @(posedge CLK);
    #1;
    DCS = 1'b0;
    DWR = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  logic [31:0] c0, c1;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h1122_3344, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'h2, 32'hAABB_CCDD, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h1122_CC44, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0014, 4'hF, 32'h5566_7788, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0014, 4'h0, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         32'h5566_7788, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_3FFC, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_3FFC, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h8000_0004, 4'h8, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h8000_0004, 4'hF, 32'h0,         32'hFF00_0000, 1'b0};
    vecs[11] = '{1'b1, 32'h8000_0004, 4'h1, 32'h0000_00A5, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h8000_0024, 4'hF, 32'h0,         32'hFF00_00A5, 1'b0};
    vecs[13] = '{1'b1, 32'h8000_0018, 4'hF, 32'h1234_5678, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h8000_0018, 4'hF, 32'h0,         32'h0, 1'b0};
    vecs[15] = '{1'b1, 32'h8000_0014, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[16] = '{1'b0, 32'h8000_000C, 4'hF, 32'h0,         32'h0, 1'b0};
    vecs[17] = '{1'b0, 32'h0001_0000, 4'hF, 32'h0,         32'h0, 1'b1};
    vecs[18] = '{1'b0, 32'h8000_000C, 4'hF, 32'h0,         32'h2, 1'b1};
    vecs[19] = '{1'b1, 32'h8000_000C, 4'h1, 32'h0000_0002, 32'h0, 1'b0};
    vecs[20] = '{1'b1, 32'h4000_0010, 4'hF, 32'h9999_9999, 32'h0, 1'b1};
    vecs[21] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h1122_CC44, 1'b1};
    vecs[22] = '{1'b0, 32'h0000_4000, 4'hF, 32'h0,         32'h0, 1'b1};
    vecs[23] = '{1'b1, 32'h8000_000C, 4'h2, 32'h0000_0202, 32'h0, 1'b1};
    vecs[24] = '{1'b1, 32'h8000_000C, 4'h1, 32'h0000_0002, 32'h0, 1'b0};
    vecs[25] = '{1'b0, 32'h8000_000C, 4'hF, 32'h0,         32'h0, 1'b0};
    vecs[26] = '{1'b0, 32'h8000_0014, 4'hF, 32'h0,         32'h0, 1'b0};
    vecs[27] = '{1'b0, 32'h0000_3FFC, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};

    RST = 1'b0; DCS = 1'b0; DWR = 1'b0; DADDR = '0; DMASK = '0; DOUT = '0;
    #2 RST = 1'b1;
    idle(2);
    check("reset DIN", DIN, 32'h0);
    check("reset IRQ", {31'd0, IRQ}, 32'h0);
    check("reset BUS_ERR", {31'd0, BUS_ERR}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      access(vecs[i].wr, vecs[i].addr, vecs[i].mask, vecs[i].data);
      if (!vecs[i].wr) check($sformatf("vec%0d DIN", i), DIN, vecs[i].exp_din);
      check($sformatf("vec%0d BUS_ERR", i), {31'd0, BUS_ERR}, {31'd0, vecs[i].exp_err});
    end

    // Cycle counter: reads ten edges apart differ by ten.
    access(1'b0, 32'h8000_0000, 4'hF, 32'h0);
    c0 = DIN;
    idle(9);
    access(1'b0, 32'h8000_0000, 4'hF, 32'h0);
    c1 = DIN;
    check("cycle delta", c1 - c0, 32'd10);

`ifdef TAWAS_DMEM_TIMER_EN
    access(1'b0, 32'h8000_0000, 4'hF, 32'h0);
    c0 = DIN;
    access(1'b1, 32'h8000_0008, 4'hF, c0 + 32'd40);
    access(1'b1, 32'h8000_0010, 4'h1, 32'h0000_0003);
    idle(37);
    check("irq before hit", {31'd0, IRQ}, 32'h0);
    idle(1);
    check("irq at hit edge", {31'd0, IRQ}, 32'h0);
    idle(1);
    check("irq after hit", {31'd0, IRQ}, 32'h1);
    access(1'b0, 32'h8000_000C, 4'hF, 32'h0);
    check("status pending", DIN, 32'h1);
    access(1'b1, 32'h8000_000C, 4'h1, 32'h0000_0001);
    idle(1);
    check("irq cleared", {31'd0, IRQ}, 32'h0);
    access(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    check("ctrl read", DIN, 32'h3);
`else
    access(1'b1, 32'h8000_0008, 4'hF, 32'h0000_0005);
    access(1'b0, 32'h8000_0008, 4'hF, 32'h0);
    check("timer_cmp absent", DIN, 32'h0);
    access(1'b1, 32'h8000_0010, 4'h1, 32'h0000_0003);
    access(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    check("ctrl absent", DIN, 32'h0);
    idle(50);
    check("irq tied low", {31'd0, IRQ}, 32'h0);
    access(1'b0, 32'h8000_000C, 4'hF, 32'h0);
    check("status no pending", DIN, 32'h0);
`endif

    // Reset in the cycle after a read: registers clear, RAM is retained.
    access(1'b0, 32'h0001_0000, 4'hF, 32'h0);
    access(1'b0, 32'h0000_0010, 4'hF, 32'h0);
    check("pre-reset DIN", DIN, 32'h1122_CC44);
    check("pre-reset BUS_ERR", {31'd0, BUS_ERR}, 32'h1);
    @(negedge CLK);
    RST = 1'b1; DCS = 1'b1; DWR = 1'b0; DADDR = 32'h0000_0014;
    #1;
    check("rst DIN", DIN, 32'h0);
    check("rst BUS_ERR", {31'd0, BUS_ERR}, 32'h0);
    check("rst IRQ", {31'd0, IRQ}, 32'h0);
    @(posedge CLK);
    #1;
    check("rst read abandoned", DIN, 32'h0);
    @(negedge CLK);
    RST = 1'b0; DCS = 1'b0;
    access(1'b0, 32'h8000_0004, 4'hF, 32'h0);
    check("scratch after rst", DIN, 32'h0);
    access(1'b0, 32'h8000_000C, 4'hF, 32'h0);
    check("status after rst", DIN, 32'h0);
    access(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    check("ctrl after rst", DIN, 32'h0);
    access(1'b0, 32'h0000_0010, 4'hF, 32'h0);
    check("ram retained", DIN, 32'h1122_CC44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
